// File: rtl/pc_gen_unit.sv
// Fetch PC generator: sequential stepping, branch/jump/return redirects and a circular return-address stack.
// Redirects and RAS updates take effect at the next rising edge; pc_ready only gates sequential advance.
module pc_gen_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ADDR_SHIFT = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pc_ready,
  input  logic                         redir_valid,
  input  logic [1:0]                   redir_type,
  input  logic                         redir_call,
  input  logic [XLEN-1:0]              redir_base,
  input  logic [XLEN-1:0]              redir_imm,
  input  logic [XLEN-1:0]              redir_rs1,
  output logic [XLEN-1:0]              pc_out,
  output logic                         pc_valid,
  output logic                         ras_miss,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int unsigned     IW   = $clog2(RAS_DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(4 >> ADDR_SHIFT);
  localparam logic [XLEN-1:0] CLR0 = ~XLEN'(1);
  localparam logic [IW:0]     FULL = (IW + 1)'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [IW-1:0]   top_idx;

  logic [XLEN-1:0] rel_off;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] target;
  logic            ras_empty;
  logic            is_ret;
  logic            do_pop;
  logic            do_push;
  logic [IW-1:0]   pop_idx;
  logic [IW-1:0]   push_idx;
  logic [IW:0]     pop_cnt;
  logic [IW:0]     push_cnt;

  assign rel_off   = $unsigned($signed(redir_imm) >>> ADDR_SHIFT);
  assign jalr_sum  = redir_rs1 + redir_imm;
  assign jalr_tgt  = (jalr_sum & CLR0) >> ADDR_SHIFT;
  assign link      = redir_base + STEP;
  assign ras_top   = ras_mem[top_idx];
  assign ras_empty = (ras_count == '0);
  assign is_ret    = (redir_type == 2'b11);
  assign do_pop    = redir_valid && is_ret && !ras_empty;
  assign do_push   = redir_valid && redir_call && (redir_type != 2'b00);

  always_comb begin
    target = redir_base + rel_off;
    case (redir_type)
      2'b10:   target = jalr_tgt;
      2'b11:   target = ras_empty ? jalr_tgt : ras_top;
      default: target = redir_base + rel_off;
    endcase
  end

  // A combined return+call is a pop followed by a push, so the push is built on the popped state.
  always_comb begin
    pop_idx  = do_pop ? top_idx - 1'b1 : top_idx;
    pop_cnt  = do_pop ? ras_count - 1'b1 : ras_count;
    push_idx = pop_idx + 1'b1;
    push_cnt = (pop_cnt == FULL) ? FULL : pop_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out    <= RESET_PC;
      pc_valid  <= 1'b0;
      ras_miss  <= 1'b0;
      ras_count <= '0;
      top_idx   <= '0;
    end else begin
      pc_valid <= 1'b1;
      ras_miss <= redir_valid && is_ret && ras_empty;
      if (redir_valid) begin
        pc_out <= target;
      end else if (pc_valid && pc_ready) begin
        pc_out <= pc_out + STEP;
      end
      if (do_push) begin
        top_idx   <= push_idx;
        ras_count <= push_cnt;
      end else if (do_pop) begin
        top_idx   <= pop_idx;
        ras_count <= pop_cnt;
      end
    end
  end

  // Circular storage: a push past full lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[push_idx] <= link;
    end
  end

endmodule
